fpu_prenorm_lanes: RTL and testbench

FPU_PRENORM_LANES -- requirements
Module: fpu_prenorm_lanes

---
 rtl/fpu_prenorm_lanes_pkg.sv | 78 +++++++
 rtl/fpu_prenorm_lanes_lane.sv | 102 ++++++++++
 rtl/lzc.sv | 38 +++
 rtl/fpu_prenorm_lanes.sv | 146 ++++++++++++++
 tb/tb_fpu_prenorm_lanes.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_prenorm_lanes_pkg.sv
// ============================================================================
// Module   : defs_div_sqrt_mvp (package)
// Brief    : Shared widths, encodings and the per-format operand unpacker
//            for the div/sqrt pre-normalisation lanes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package defs_div_sqrt_mvp;

    localparam int C_RM           = 3;
    localparam int C_FS           = 2;
    localparam int C_OP_FP64      = 64;
    localparam int C_EXP_FP64     = 11;
    localparam int C_MANT_FP64    = 52;
    localparam int C_EXP_NORM_W   = C_EXP_FP64 + 1;
    localparam int C_CLASS_W      = 5;
    localparam int C_LZC_W        = C_MANT_FP64 + 1;
    localparam int C_LZC_CNT_W    = 6;

    localparam logic [C_FS-1:0] C_FMT_FP32    = 2'b00;
    localparam logic [C_FS-1:0] C_FMT_FP64    = 2'b01;
    localparam logic [C_FS-1:0] C_FMT_FP16    = 2'b10;
    localparam logic [C_FS-1:0] C_FMT_FP16ALT = 2'b11;

    localparam logic C_OP_DIV  = 1'b0;
    localparam logic C_OP_SQRT = 1'b1;

    // Class vector bit positions: {SNaN, NaN, Inf, Zero, Subnormal}
    localparam int C_CLS_SNAN = 4;
    localparam int C_CLS_NAN  = 3;
    localparam int C_CLS_INF  = 2;
    localparam int C_CLS_ZERO = 1;
    localparam int C_CLS_SUBN = 0;

    typedef struct packed {
        logic                   sign;
        logic [C_EXP_FP64-1:0]  exp_f;
        logic [C_MANT_FP64-1:0] mant_f;
        logic                   exp_max;
    } fp_unpacked_t;

    // Fields are taken LSB-aligned; the mantissa is left-aligned to 52 bits.
    function automatic fp_unpacked_t fp_unpack(input logic [C_FS-1:0] fmt,
                                               input logic [C_OP_FP64-1:0] op);
        fp_unpacked_t u;
        case (fmt)
            C_FMT_FP32: begin
                u.sign    = op[31];
                u.exp_f   = {3'b000, op[30:23]};
                u.mant_f  = {op[22:0], 29'b0};
                u.exp_max = &op[30:23];
            end
            C_FMT_FP64: begin
                u.sign    = op[63];
                u.exp_f   = op[62:52];
                u.mant_f  = op[51:0];
                u.exp_max = &op[62:52];
            end
            C_FMT_FP16: begin
                u.sign    = op[15];
                u.exp_f   = {6'b000000, op[14:10]};
                u.mant_f  = {op[9:0], 42'b0};
                u.exp_max = &op[14:10];
            end
            default: begin
                u.sign    = op[15];
                u.exp_f   = {3'b000, op[14:7]};
                u.mant_f  = {op[6:0], 45'b0};
                u.exp_max = &op[14:7];
            end
        endcase
        return u;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fpu_prenorm_lanes_lane.sv
// ============================================================================
// Module   : prenorm_lane
// Brief    : One lane of unpack, classify and leading-zero normalisation for
//            a div/sqrt operand pair (purely combinational).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prenorm_lane
    import defs_div_sqrt_mvp::*;
(
    input  logic                    Op_SI,
    input  logic [C_FS-1:0]         Format_sel_SI,
    input  logic [C_OP_FP64-1:0]    Operand_a_DI,
    input  logic [C_OP_FP64-1:0]    Operand_b_DI,
    output logic [C_EXP_NORM_W-1:0] Exp_a_DO,
    output logic [C_EXP_NORM_W-1:0] Exp_b_DO,
    output logic [C_MANT_FP64:0]    Mant_a_DO,
    output logic [C_MANT_FP64:0]    Mant_b_DO,
    output logic [C_CLASS_W-1:0]    Class_a_DO,
    output logic [C_CLASS_W-1:0]    Class_b_DO,
    output logic                    Sign_z_DO,
    output logic                    Special_SO,
    output logic                    Nv_SO
);

    logic [C_OP_FP64-1:0]    w_operand [2];
    fp_unpacked_t            w_unp     [2];
    logic [C_MANT_FP64:0]    w_sig     [2];
    logic [C_LZC_CNT_W-1:0]  w_lz      [2];
    logic                    w_empty   [2];
    logic [C_EXP_NORM_W-1:0] w_exp     [2];
    logic [C_MANT_FP64:0]    w_mant    [2];
    logic [C_CLASS_W-1:0]    w_cls     [2];
    logic                    w_spec    [2];

    assign w_operand[0] = Operand_a_DI;
    assign w_operand[1] = Operand_b_DI;

    for (genvar i = 0; i < 2; i++) begin : g_operand
        logic w_exp_zero;
        logic w_mant_nz;
        logic w_nan;

        assign w_unp[i]   = fp_unpack(Format_sel_SI, w_operand[i]);
        assign w_sig[i]   = {|w_unp[i].exp_f, w_unp[i].mant_f};

        lzc #(
            .WIDTH (C_LZC_W),
            .MODE  (1'b1)
        ) i_lzc (
            .in_i    (w_sig[i]),
            .cnt_o   (w_lz[i]),
            .empty_o (w_empty[i])
        );

        // Subnormals keep an effective exponent of 1 before the shift is applied.
        assign w_mant[i] = w_empty[i] ? '0 : (w_sig[i] << w_lz[i]);
        assign w_exp[i]  = w_empty[i] ? '0 :
                           ({1'b0, w_unp[i].exp_f} - C_EXP_NORM_W'(w_lz[i])
                            + C_EXP_NORM_W'(w_lz[i] != '0));

        assign w_exp_zero = (w_unp[i].exp_f == '0);
        assign w_mant_nz  = |w_unp[i].mant_f;
        assign w_nan      = w_unp[i].exp_max & w_mant_nz;

        assign w_cls[i][C_CLS_SNAN] = w_nan & ~w_unp[i].mant_f[C_MANT_FP64-1];
        assign w_cls[i][C_CLS_NAN]  = w_nan;
        assign w_cls[i][C_CLS_INF]  = w_unp[i].exp_max & ~w_mant_nz;
        assign w_cls[i][C_CLS_ZERO] = w_exp_zero & ~w_mant_nz;
        assign w_cls[i][C_CLS_SUBN] = w_exp_zero & w_mant_nz;

        assign w_spec[i] = w_cls[i][C_CLS_NAN] | w_cls[i][C_CLS_INF] | w_cls[i][C_CLS_ZERO];
    end

    logic w_is_div;
    logic w_sign_a;
    logic w_sign_b;

    assign w_is_div = (Op_SI == C_OP_DIV);
    assign w_sign_a = w_unp[0].sign;
    assign w_sign_b = w_unp[1].sign;

    assign Exp_a_DO   = w_exp[0];
    assign Mant_a_DO  = w_mant[0];
    assign Class_a_DO = w_cls[0];
    assign Exp_b_DO   = w_is_div ? w_exp[1]  : '0;
    assign Mant_b_DO  = w_is_div ? w_mant[1] : '0;
    assign Class_b_DO = w_is_div ? w_cls[1]  : '0;

    assign Sign_z_DO  = w_is_div ? (w_sign_a ^ w_sign_b) : w_sign_a;
    assign Special_SO = w_is_div ? (w_spec[0] | w_spec[1]) : (w_spec[0] | w_sign_a);

    assign Nv_SO = w_cls[0][C_CLS_SNAN]
                 | (w_is_div & (w_cls[1][C_CLS_SNAN]
                               | (w_cls[0][C_CLS_ZERO] & w_cls[1][C_CLS_ZERO])
                               | (w_cls[0][C_CLS_INF]  & w_cls[1][C_CLS_INF])))
                 | (~w_is_div & w_sign_a & ~w_cls[0][C_CLS_ZERO] & ~w_cls[0][C_CLS_NAN]);

endmodule

`default_nettype wire

// File: rtl/lzc.sv
// ============================================================================
// Module   : lzc
// Brief    : Leading (MODE=1) or trailing (MODE=0) zero counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lzc #(
    parameter int unsigned WIDTH     = 2,
    parameter bit          MODE      = 1'b0,
    parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0]     in_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 empty_o
);

    logic [WIDTH-1:0] w_ordered;

    for (genvar g = 0; g < WIDTH; g++) begin : g_order
        assign w_ordered[g] = MODE ? in_i[WIDTH-1-g] : in_i[g];
    end

    // Scan downwards so the lowest count with a set bit wins.
    always_comb begin
        cnt_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_ordered[i]) begin
                cnt_o = CNT_WIDTH'(i);
            end
        end
    end

    assign empty_o = ~|in_i;

endmodule

`default_nettype wire

// File: rtl/fpu_prenorm_lanes.sv
// ============================================================================
// Module   : fpu_prenorm_lanes
// Brief    : Multi-lane div/sqrt operand pre-normalisation with a single
//            registered output stage and valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_prenorm_lanes
    import defs_div_sqrt_mvp::*;
#(
    parameter int NUM_LANES = 2,
    parameter int TAG_W     = 4
) (
    input  logic                                Clk_CI,
    input  logic                                Rst_RBI,
    input  logic                                In_valid_SI,
    output logic                                In_ready_SO,
    input  logic                                Op_SI,
    input  logic [C_FS-1:0]                     Format_sel_SI,
    input  logic [C_RM-1:0]                     RM_SI,
    input  logic [TAG_W-1:0]                    Tag_SI,
    input  logic [NUM_LANES*C_OP_FP64-1:0]      Operand_a_DI,
    input  logic [NUM_LANES*C_OP_FP64-1:0]      Operand_b_DI,
    input  logic                                Flush_SI,
    output logic                                Out_valid_SO,
    input  logic                                Out_ready_SI,
    output logic [NUM_LANES*C_EXP_NORM_W-1:0]   Exp_a_DO,
    output logic [NUM_LANES*C_EXP_NORM_W-1:0]   Exp_b_DO,
    output logic [NUM_LANES*(C_MANT_FP64+1)-1:0] Mant_a_DO,
    output logic [NUM_LANES*(C_MANT_FP64+1)-1:0] Mant_b_DO,
    output logic [NUM_LANES*C_CLASS_W-1:0]      Class_a_DO,
    output logic [NUM_LANES*C_CLASS_W-1:0]      Class_b_DO,
    output logic [NUM_LANES-1:0]                Sign_z_DO,
    output logic [NUM_LANES-1:0]                Special_SO,
    output logic [NUM_LANES-1:0]                Nv_SO,
    output logic                                Op_SO,
    output logic [C_FS-1:0]                     Format_SO,
    output logic [C_RM-1:0]                     RM_SO,
    output logic [TAG_W-1:0]                    Tag_SO
);

    localparam int C_MW = C_MANT_FP64 + 1;

    logic [NUM_LANES*C_EXP_NORM_W-1:0] exp_a_d,   exp_a_q;
    logic [NUM_LANES*C_EXP_NORM_W-1:0] exp_b_d,   exp_b_q;
    logic [NUM_LANES*C_MW-1:0]         mant_a_d,  mant_a_q;
    logic [NUM_LANES*C_MW-1:0]         mant_b_d,  mant_b_q;
    logic [NUM_LANES*C_CLASS_W-1:0]    class_a_d, class_a_q;
    logic [NUM_LANES*C_CLASS_W-1:0]    class_b_d, class_b_q;
    logic [NUM_LANES-1:0]              sign_z_d,  sign_z_q;
    logic [NUM_LANES-1:0]              special_d, special_q;
    logic [NUM_LANES-1:0]              nv_d,      nv_q;
    logic                              op_q;
    logic [C_FS-1:0]                   format_q;
    logic [C_RM-1:0]                   rm_q;
    logic [TAG_W-1:0]                  tag_q;
    logic                              out_valid_q;

    logic w_in_ready;
    logic w_accept;

    // A flush blocks new work so the discarded slot stays empty for a cycle.
    assign w_in_ready = (~out_valid_q | Out_ready_SI) & ~Flush_SI;
    assign w_accept   = In_valid_SI & w_in_ready;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        prenorm_lane i_lane (
            .Op_SI         (Op_SI),
            .Format_sel_SI (Format_sel_SI),
            .Operand_a_DI  (Operand_a_DI[l*C_OP_FP64 +: C_OP_FP64]),
            .Operand_b_DI  (Operand_b_DI[l*C_OP_FP64 +: C_OP_FP64]),
            .Exp_a_DO      (exp_a_d[l*C_EXP_NORM_W +: C_EXP_NORM_W]),
            .Exp_b_DO      (exp_b_d[l*C_EXP_NORM_W +: C_EXP_NORM_W]),
            .Mant_a_DO     (mant_a_d[l*C_MW +: C_MW]),
            .Mant_b_DO     (mant_b_d[l*C_MW +: C_MW]),
            .Class_a_DO    (class_a_d[l*C_CLASS_W +: C_CLASS_W]),
            .Class_b_DO    (class_b_d[l*C_CLASS_W +: C_CLASS_W]),
            .Sign_z_DO     (sign_z_d[l]),
            .Special_SO    (special_d[l]),
            .Nv_SO         (nv_d[l])
        );
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            out_valid_q <= 1'b0;
            exp_a_q     <= '0;
            exp_b_q     <= '0;
            mant_a_q    <= '0;
            mant_b_q    <= '0;
            class_a_q   <= '0;
            class_b_q   <= '0;
            sign_z_q    <= '0;
            special_q   <= '0;
            nv_q        <= '0;
            op_q        <= 1'b0;
            format_q    <= '0;
            rm_q        <= '0;
            tag_q       <= '0;
        end else begin
            if (Flush_SI) begin
                out_valid_q <= 1'b0;
            end else if (w_accept) begin
                out_valid_q <= 1'b1;
            end else if (Out_ready_SI) begin
                out_valid_q <= 1'b0;
            end

            if (w_accept) begin
                exp_a_q   <= exp_a_d;
                exp_b_q   <= exp_b_d;
                mant_a_q  <= mant_a_d;
                mant_b_q  <= mant_b_d;
                class_a_q <= class_a_d;
                class_b_q <= class_b_d;
                sign_z_q  <= sign_z_d;
                special_q <= special_d;
                nv_q      <= nv_d;
                op_q      <= Op_SI;
                format_q  <= Format_sel_SI;
                rm_q      <= RM_SI;
                tag_q     <= Tag_SI;
            end
        end
    end

    assign In_ready_SO  = w_in_ready;
    assign Out_valid_SO = out_valid_q;
    assign Exp_a_DO     = exp_a_q;
    assign Exp_b_DO     = exp_b_q;
    assign Mant_a_DO    = mant_a_q;
    assign Mant_b_DO    = mant_b_q;
    assign Class_a_DO   = class_a_q;
    assign Class_b_DO   = class_b_q;
    assign Sign_z_DO    = sign_z_q;
    assign Special_SO   = special_q;
    assign Nv_SO        = nv_q;
    assign Op_SO        = op_q;
    assign Format_SO    = format_q;
    assign RM_SO        = rm_q;
    assign Tag_SO       = tag_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_prenorm_lanes.sv
// ============================================================================
// Module   : tb_fpu_prenorm_lanes
// Brief    : Self-checking bench for fpu_prenorm_lanes with a reference
//            model feeding a transaction scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fpu_prenorm_lanes;

    localparam int NL = 4;
    localparam int TW = 4;

    logic              Clk_CI = 1'b0;
    logic              Rst_RBI = 1'b0;
    logic              In_valid_SI = 1'b0;
    logic              In_ready_SO;
    logic              Op_SI = 1'b0;
    logic [1:0]        Format_sel_SI = '0;
    logic [2:0]        RM_SI = '0;
    logic [TW-1:0]     Tag_SI = '0;
    logic [NL*64-1:0]  Operand_a_DI = '0;
    logic [NL*64-1:0]  Operand_b_DI = '0;
    logic              Flush_SI = 1'b0;
    logic              Out_valid_SO;
    logic              Out_ready_SI = 1'b0;
    logic [NL*12-1:0]  Exp_a_DO, Exp_b_DO;
    logic [NL*53-1:0]  Mant_a_DO, Mant_b_DO;
    logic [NL*5-1:0]   Class_a_DO, Class_b_DO;
    logic [NL-1:0]     Sign_z_DO, Special_SO, Nv_SO;
    logic              Op_SO;
    logic [1:0]        Format_SO;
    logic [2:0]        RM_SO;
    logic [TW-1:0]     Tag_SO;

    always #5 Clk_CI = ~Clk_CI;

    fpu_prenorm_lanes #(.NUM_LANES(NL), .TAG_W(TW)) dut (
        .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI),
        .In_valid_SI(In_valid_SI), .In_ready_SO(In_ready_SO),
        .Op_SI(Op_SI), .Format_sel_SI(Format_sel_SI), .RM_SI(RM_SI), .Tag_SI(Tag_SI),
        .Operand_a_DI(Operand_a_DI), .Operand_b_DI(Operand_b_DI),
        .Flush_SI(Flush_SI), .Out_valid_SO(Out_valid_SO), .Out_ready_SI(Out_ready_SI),
        .Exp_a_DO(Exp_a_DO), .Exp_b_DO(Exp_b_DO), .Mant_a_DO(Mant_a_DO), .Mant_b_DO(Mant_b_DO),
        .Class_a_DO(Class_a_DO), .Class_b_DO(Class_b_DO),
        .Sign_z_DO(Sign_z_DO), .Special_SO(Special_SO), .Nv_SO(Nv_SO),
        .Op_SO(Op_SO), .Format_SO(Format_SO), .RM_SO(RM_SO), .Tag_SO(Tag_SO)
    );

    typedef struct packed {
        logic [11:0] ea; logic [52:0] ma; logic [4:0] ca;
        logic [11:0] eb; logic [52:0] mb; logic [4:0] cb;
        logic sz; logic sp; logic nv;
    } lane_t;

    typedef struct packed {
        logic [NL*12-1:0] ea; logic [NL*53-1:0] ma; logic [NL*5-1:0] ca;
        logic [NL*12-1:0] eb; logic [NL*53-1:0] mb; logic [NL*5-1:0] cb;
        logic [NL-1:0] sz; logic [NL-1:0] sp; logic [NL-1:0] nv;
        logic op; logic [1:0] fmt; logic [2:0] rm; logic [TW-1:0] tag;
    } txn_t;

    txn_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void fmt_w(input logic [1:0] f, output int ew, output int mw);
        case (f)
            2'b00:   begin ew = 8;  mw = 23; end
            2'b01:   begin ew = 11; mw = 52; end
            2'b10:   begin ew = 5;  mw = 10; end
            default: begin ew = 8;  mw = 7;  end
        endcase
    endfunction

    function automatic void ref_unpack(input logic [1:0] f, input logic [63:0] x,
                                       output logic s, output logic [11:0] e12,
                                       output logic [52:0] m53, output logic [4:0] cls);
        int ew, mw, sh;
        logic [63:0] e, m, emax;
        logic [51:0] m52;
        fmt_w(f, ew, mw);
        e    = (x >> mw) & ((64'd1 << ew) - 64'd1);
        m    = x & ((64'd1 << mw) - 64'd1);
        emax = (64'd1 << ew) - 64'd1;
        m52  = 52'(m << (52 - mw));
        s    = x[ew + mw];
        cls  = '0;
        if (e == 0 && m == 0) cls[1] = 1'b1;
        if (e == 0 && m != 0) cls[0] = 1'b1;
        if (e == emax && m == 0) cls[2] = 1'b1;
        if (e == emax && m != 0) begin cls[3] = 1'b1; cls[4] = ~m52[51]; end
        if (cls[1]) begin
            e12 = '0; m53 = '0;
        end else if (e != 0) begin
            e12 = 12'(e); m53 = {1'b1, m52};
        end else begin
            sh = 0;
            while (!m52[51]) begin m52 = m52 << 1; sh++; end
            m53 = {m52, 1'b0};
            e12 = 12'(-sh);
        end
    endfunction

    function automatic lane_t model_lane(input logic op, input logic [1:0] f,
                                         input logic [63:0] a, input logic [63:0] b);
        lane_t r;
        logic sa, sb_s, div;
        logic [4:0] cbr;
        div = (op == 1'b0);
        ref_unpack(f, a, sa, r.ea, r.ma, r.ca);
        ref_unpack(f, b, sb_s, r.eb, r.mb, cbr);
        r.cb = cbr;
        if (!div) begin r.eb = '0; r.mb = '0; r.cb = '0; end
        r.sz = div ? (sa ^ sb_s) : sa;
        r.sp = div ? (|r.ca[3:1] | |cbr[3:1]) : (|r.ca[3:1] | sa);
        r.nv = r.ca[4] | (div & cbr[4]) | (div & r.ca[1] & cbr[1]) | (div & r.ca[2] & cbr[2])
             | (!div & sa & !r.ca[1] & !r.ca[3]);
        return r;
    endfunction

    function automatic txn_t model_txn();
        txn_t t;
        lane_t r;
        for (int l = 0; l < NL; l++) begin
            r = model_lane(Op_SI, Format_sel_SI, Operand_a_DI[64*l +: 64], Operand_b_DI[64*l +: 64]);
            t.ea[12*l +: 12] = r.ea; t.ma[53*l +: 53] = r.ma; t.ca[5*l +: 5] = r.ca;
            t.eb[12*l +: 12] = r.eb; t.mb[53*l +: 53] = r.mb; t.cb[5*l +: 5] = r.cb;
            t.sz[l] = r.sz; t.sp[l] = r.sp; t.nv[l] = r.nv;
        end
        t.op = Op_SI; t.fmt = Format_sel_SI; t.rm = RM_SI; t.tag = Tag_SI;
        return t;
    endfunction

    task automatic compare_txn(input txn_t e);
        check("exp_a",   256'(Exp_a_DO),   256'(e.ea));
        check("mant_a",  256'(Mant_a_DO),  256'(e.ma));
        check("class_a", 256'(Class_a_DO), 256'(e.ca));
        check("exp_b",   256'(Exp_b_DO),   256'(e.eb));
        check("mant_b",  256'(Mant_b_DO),  256'(e.mb));
        check("class_b", 256'(Class_b_DO), 256'(e.cb));
        check("sign_z",  256'(Sign_z_DO),  256'(e.sz));
        check("special", 256'(Special_SO), 256'(e.sp));
        check("nv",      256'(Nv_SO),      256'(e.nv));
        check("op",      256'(Op_SO),      256'(e.op));
        check("format",  256'(Format_SO),  256'(e.fmt));
        check("rm",      256'(RM_SO),      256'(e.rm));
        check("tag",     256'(Tag_SO),     256'(e.tag));
    endtask

    // Observe mid-cycle, predict this edge's transfers, then advance one clock.
    task automatic tick();
        @(negedge Clk_CI);
        check("out_valid_occupancy", 256'(Out_valid_SO), 256'(sb.size() != 0));
        if (Flush_SI) begin
            if (sb.size() != 0) void'(sb.pop_front());
        end else if (Out_valid_SO && Out_ready_SI && sb.size() != 0) begin
            compare_txn(sb.pop_front());
        end
        if (In_valid_SI && In_ready_SO) sb.push_back(model_txn());
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic drive(input logic op, input logic [1:0] f, input logic [2:0] rm,
                         input logic [TW-1:0] tag, input logic [NL*64-1:0] a,
                         input logic [NL*64-1:0] b);
        Op_SI = op; Format_sel_SI = f; RM_SI = rm; Tag_SI = tag;
        Operand_a_DI = a; Operand_b_DI = b;
    endtask

    function automatic logic [63:0] gen_op(input logic [1:0] f);
        int ew, mw;
        logic [63:0] r, em, mm;
        fmt_w(f, ew, mw);
        r  = {$urandom, $urandom};
        mm = (64'd1 << mw) - 64'd1;
        em = ((64'd1 << ew) - 64'd1) << mw;
        case ($urandom_range(0, 5))
            0: r = r & ~(em | mm);
            1: r = r & ~em;
            2: r = r | em;
            3: r = (r | em) & ~mm;
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [NL*64-1:0] gen_vec(input logic [1:0] f);
        logic [NL*64-1:0] v;
        for (int l = 0; l < NL; l++) v[64*l +: 64] = gen_op(f);
        return v;
    endfunction

    logic [NL*64-1:0] va, vb;
    logic [1:0]       rf;

    initial begin
        #12;
        check("reset_out_valid", 256'(Out_valid_SO), 256'(0));
        check("reset_exp_a",     256'(Exp_a_DO),     256'(0));
        check("reset_mant_a",    256'(Mant_a_DO),    256'(0));
        check("reset_tag",       256'(Tag_SO),       256'(0));
        check("reset_in_ready",  256'(In_ready_SO),  256'(1));
        @(posedge Clk_CI); #1;
        Rst_RBI = 1'b1;

        // FP64 div: 1.0 / smallest subnormal
        va = gen_vec(2'b01); vb = gen_vec(2'b01);
        va[63:0] = 64'h3FF0_0000_0000_0000; vb[63:0] = 64'h0000_0000_0000_0001;
        drive(1'b0, 2'b01, 3'b010, 4'h1, va, vb);
        In_valid_SI = 1'b1; Out_ready_SI = 1'b1;
        tick();
        check("fp64_exp_a",   256'(Exp_a_DO[11:0]),  256'(12'h3FF));
        check("fp64_mant_a",  256'(Mant_a_DO[52:0]), 256'(53'h10000000000000));
        check("fp64_exp_b",   256'(Exp_b_DO[11:0]),  256'(12'hFCD));
        check("fp64_class_b", 256'(Class_b_DO[4:0]), 256'(5'b00001));
        check("fp64_special", 256'(Special_SO[0]),   256'(0));
        check("fp64_nv",      256'(Nv_SO[0]),        256'(0));

        // FP32 div: sNaN / 1.0, garbage in the unused upper bits
        va = gen_vec(2'b00); vb = gen_vec(2'b00);
        va[63:0] = 64'hDEAD_BEEF_7F80_0001; vb[63:0] = 64'h0000_0000_3F80_0000;
        drive(1'b0, 2'b00, 3'b001, 4'h2, va, vb);
        tick();
        check("fp32_class_a", 256'(Class_a_DO[4:0]), 256'(5'b11000));
        check("fp32_special", 256'(Special_SO[0]),   256'(1));
        check("fp32_nv",      256'(Nv_SO[0]),        256'(1));
        check("fp32_exp_b",   256'(Exp_b_DO[11:0]),  256'(12'h07F));

        // FP16 sqrt of -1.0
        va = gen_vec(2'b10); vb = gen_vec(2'b10);
        va[63:0] = 64'h0000_0000_0000_BC00;
        drive(1'b1, 2'b10, 3'b100, 4'h3, va, vb);
        tick();
        check("fp16_sign_z",  256'(Sign_z_DO[0]),    256'(1));
        check("fp16_special", 256'(Special_SO[0]),   256'(1));
        check("fp16_nv",      256'(Nv_SO[0]),        256'(1));
        check("fp16_class_b", 256'(Class_b_DO[4:0]), 256'(0));

        // Four distinct FP16ALT lanes: normal, subnormal, sNaN, zero
        va = {64'h0, 64'h7F81, 64'h0001, 64'h3F80};
        vb = {64'h4000, 64'h3F80, 64'h0000, 64'h8001};
        drive(1'b0, 2'b11, 3'b000, 4'h4, va, vb);
        tick();
        In_valid_SI = 1'b0;
        tick();

        // Stall with a pending transaction, then drain and accept together
        Out_ready_SI = 1'b0; In_valid_SI = 1'b1;
        drive(1'b0, 2'b01, 3'b011, 4'h5, gen_vec(2'b01), gen_vec(2'b01));
        tick();
        drive(1'b1, 2'b00, 3'b001, 4'h6, gen_vec(2'b00), gen_vec(2'b00));
        for (int k = 0; k < 3; k++) begin
            check("stall_in_ready", 256'(In_ready_SO), 256'(0));
            check("stall_tag",      256'(Tag_SO),      256'(4'h5));
            check("stall_exp_a",    256'(Exp_a_DO),    256'(sb[0].ea));
            tick();
        end
        Out_ready_SI = 1'b1;
        tick();
        check("no_bubble_valid", 256'(Out_valid_SO), 256'(1));
        check("no_bubble_tag",   256'(Tag_SO),       256'(4'h6));
        In_valid_SI = 1'b0;
        tick();

        // Flush a stalled output
        Out_ready_SI = 1'b0; In_valid_SI = 1'b1;
        drive(1'b0, 2'b10, 3'b000, 4'h7, gen_vec(2'b10), gen_vec(2'b10));
        tick();
        Flush_SI = 1'b1; Out_ready_SI = 1'b1;
        drive(1'b0, 2'b10, 3'b000, 4'h8, gen_vec(2'b10), gen_vec(2'b10));
        check("flush_in_ready", 256'(In_ready_SO), 256'(0));
        tick();
        Flush_SI = 1'b0; In_valid_SI = 1'b0;
        check("flush_out_valid", 256'(Out_valid_SO), 256'(0));
        tick();

        // Asynchronous reset in the middle of a stall
        Out_ready_SI = 1'b0; In_valid_SI = 1'b1;
        drive(1'b1, 2'b01, 3'b111, 4'h9, gen_vec(2'b01), gen_vec(2'b01));
        tick();
        In_valid_SI = 1'b0;
        #2 Rst_RBI = 1'b0;
        #1;
        check("rst_out_valid", 256'(Out_valid_SO), 256'(0));
        check("rst_exp_a",     256'(Exp_a_DO),     256'(0));
        check("rst_mant_a",    256'(Mant_a_DO),    256'(0));
        check("rst_class_a",   256'(Class_a_DO),   256'(0));
        check("rst_sign_z",    256'(Sign_z_DO),    256'(0));
        check("rst_tag",       256'(Tag_SO),       256'(0));
        check("rst_in_ready",  256'(In_ready_SO),  256'(1));
        sb.delete();
        @(posedge Clk_CI); #1;
        Rst_RBI = 1'b1;

        // Random traffic with random back-pressure
        for (int n = 0; n < 60; n++) begin
            rf = 2'($urandom_range(0, 3));
            drive(1'($urandom_range(0, 1)), rf, 3'($urandom_range(0, 4)),
                  TW'($urandom), gen_vec(rf), gen_vec(rf));
            In_valid_SI  = ($urandom_range(0, 3) != 0);
            Out_ready_SI = ($urandom_range(0, 3) != 0);
            tick();
        end
        In_valid_SI = 1'b0; Out_ready_SI = 1'b1;
        tick();
        tick();
        check("scoreboard_drained", 256'(sb.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
